// File: rtl/mult_pkg.sv
// mult_pkg: shared widths, FSM state encoding and Booth op decode for booth_mult_seq.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: DATA_W operand width, PROD_W product register width (guard bit excluded),
// ITER_W iteration counter width, state_t FSM states, booth_op_t Booth recoding ops.
package mult_pkg;

  localparam int DATA_W = 32;
  localparam int PROD_W = 2 * DATA_W + 1;
  localparam int ITER_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    NOP = 2'd0,
    ADD = 2'd1,
    SUB = 2'd2
  } booth_op_t;

  // Radix-2 Booth recoding of the current multiplier LSB and the Q-1 bit.
  function automatic booth_op_t booth_decode(input logic q0, input logic qm1);
    booth_op_t op;
    case ({q0, qm1})
      2'b01:   op = ADD;
      2'b10:   op = SUB;
      default: op = NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_step.sv
// booth_step: one radix-2 Booth iteration (conditional add/sub of M, then arithmetic shift right).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   i_reg  in   PROD_W+1  {guard, A, Q, Q-1} working register
//   i_m    in   DATA_W    latched multiplicand M
//   o_reg  out  PROD_W+1  register after the add/sub and the 1-bit arithmetic shift
module booth_step
  import mult_pkg::*;
(
  input  logic [PROD_W:0]   i_reg,
  input  logic [DATA_W-1:0] i_m,
  output logic [PROD_W:0]   o_reg
);

  logic [DATA_W:0] w_acc;
  logic [DATA_W:0] w_m_ext;
  logic [DATA_W:0] w_sum;
  booth_op_t       w_op;

  // {guard, A} forms a 33-bit signed accumulator, so A - M cannot wrap even for M = -2^31.
  assign w_acc   = i_reg[PROD_W:DATA_W+1];
  assign w_m_ext = {i_m[DATA_W-1], i_m};
  assign w_op    = booth_decode(i_reg[1], i_reg[0]);

  always_comb begin
    w_sum = w_acc;
    case (w_op)
      ADD:     w_sum = w_acc + w_m_ext;
      SUB:     w_sum = w_acc - w_m_ext;
      default: w_sum = w_acc;
    endcase
  end

  // Arithmetic shift right of {sum, Q, Q-1}: the guard bit replicates, old Q[0] becomes Q-1.
  assign o_reg = {w_sum[DATA_W], w_sum, i_reg[DATA_W:1]};

endmodule

// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential radix-2 Booth multiplier, signed 32x32 -> 64, one step per clock.
// Latency: 32 cycles from the start edge to the result_rdy pulse (1 cycle for zero operands
//   when MULT_ZERO_BYPASS_EN is defined).
// Backpressure: none; ctrl_mult is honoured in every state and restarts the unit, aborting any op.
//
// Optional feature macro: MULT_ZERO_BYPASS_EN (zero operand short-cuts straight to DONE).
//
// Ports:
//   clock           in   rising-edge clock
//   reset_n         in   asynchronous active-low reset
//   ctrl_mult       in   start pulse, operands sampled when high
//   multiplicand    in   DATA_W signed operand M
//   multiplier      in   DATA_W signed operand Q
//   busy            out  high while iterating
//   result_rdy      out  one-cycle completion pulse
//   product         out  PROD_W Booth register: [64:1] signed product, [0] Booth Q-1 bit
//   result          out  DATA_W low product word, product[32:1]
//   multiplicand_q  out  DATA_W multiplicand latched at start
//   multiplier_q    out  DATA_W multiplier latched at start
module booth_mult_seq
  import mult_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ctrl_mult,
  input  logic [DATA_W-1:0] multiplicand,
  input  logic [DATA_W-1:0] multiplier,
  output logic              busy,
  output logic              result_rdy,
  output logic [PROD_W-1:0] product,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] multiplicand_q,
  output logic [DATA_W-1:0] multiplier_q
);

  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(DATA_W - 1);

  state_t            r_state;
  logic [ITER_W-1:0] r_cnt;
  logic [PROD_W:0]   r_acc;     // {guard, A, Q, Q-1}
  logic [PROD_W:0]   w_step;

`ifdef MULT_ZERO_BYPASS_EN
  logic r_zero_pend;            // zero operand seen at start; finish on the next edge
  logic w_zero_op;
  assign w_zero_op = (multiplicand == '0) || (multiplier == '0);
`endif

  booth_step u_step (
    .i_reg (r_acc),
    .i_m   (multiplicand_q),
    .o_reg (w_step)
  );

  // The guard bit is internal only; downstream sees the 65-bit Booth register.
  assign product = r_acc[PROD_W-1:0];
  assign result  = r_acc[DATA_W:1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_acc          <= '0;
      busy           <= 1'b0;
      result_rdy     <= 1'b0;
      multiplicand_q <= '0;
      multiplier_q   <= '0;
`ifdef MULT_ZERO_BYPASS_EN
      r_zero_pend    <= 1'b0;
`endif
    end else begin
      // result_rdy is a single-cycle pulse unless a completion below re-asserts it.
      result_rdy <= 1'b0;

      if (ctrl_mult) begin
        // A start wins in every state; an op in flight is dropped without a pulse.
        multiplicand_q <= multiplicand;
        multiplier_q   <= multiplier;
        r_cnt          <= '0;
        busy           <= 1'b1;
`ifdef MULT_ZERO_BYPASS_EN
        if (w_zero_op) begin
          // Product is known to be zero; park in IDLE for one cycle then report.
          r_acc       <= '0;
          r_state     <= IDLE;
          r_zero_pend <= 1'b1;
        end else begin
          r_acc       <= {1'b0, {DATA_W{1'b0}}, multiplier, 1'b0};
          r_state     <= RUN;
          r_zero_pend <= 1'b0;
        end
`else
        r_acc   <= {1'b0, {DATA_W{1'b0}}, multiplier, 1'b0};
        r_state <= RUN;
`endif
      end else begin
        case (r_state)
          IDLE: begin
`ifdef MULT_ZERO_BYPASS_EN
            if (r_zero_pend) begin
              r_zero_pend <= 1'b0;
              r_state     <= DONE;
              busy        <= 1'b0;
              result_rdy  <= 1'b1;
            end
`endif
          end

          RUN: begin
            r_acc <= w_step;
            // Count value 31 marks the final step; it is consumed on this edge.
            if (r_cnt == LAST_ITER) begin
              r_state    <= DONE;
              busy       <= 1'b0;
              result_rdy <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end

          DONE: begin
            // Product and latched operands are left untouched for the overflow checker.
            r_state <= IDLE;
          end

          default: begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: scoreboard bench for booth_mult_seq against a plain-arithmetic product model.
// Latency: checks 32-cycle (or bypass 1-cycle) start-to-result_rdy spacing.
// Backpressure: n/a; stimulus and checking run as separate processes.
module tb_booth_mult_seq;

  logic        clock;
  logic        reset_n;
  logic        ctrl_mult;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        result_rdy;
  logic [64:0] product;
  logic [31:0] result;
  logic [31:0] multiplicand_q;
  logic [31:0] multiplier_q;

  booth_mult_seq dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_mult      (ctrl_mult),
    .multiplicand   (multiplicand),
    .multiplier     (multiplier),
    .busy           (busy),
    .result_rdy     (result_rdy),
    .product        (product),
    .result         (result),
    .multiplicand_q (multiplicand_q),
    .multiplier_q   (multiplier_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] p;
    logic        q1;
    logic [31:0] m;
    logic [31:0] q;
    int          t0;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: signed product by ordinary 64-bit arithmetic.
  function automatic exp_t model(input logic [31:0] m, input logic [31:0] q, input int t0);
    exp_t e;
    longint sm;
    longint sq;
    logic   zero;
    sm   = longint'($signed(m));
    sq   = longint'($signed(q));
    zero = (m == 32'd0) || (q == 32'd0);
    e.p  = 64'(sm * sq);
    e.m  = m;
    e.q  = q;
    e.t0 = t0;
`ifdef MULT_ZERO_BYPASS_EN
    e.lat = zero ? 1 : 32;
    e.q1  = zero ? 1'b0 : q[31];
`else
    e.lat = 32;
    e.q1  = q[31];
`endif
    return e;
  endfunction

  // Drive a start for one edge, then scramble the operand inputs to show they are not re-read.
  task automatic start_op(input logic [31:0] m, input logic [31:0] q);
    @(negedge clock);
    ctrl_mult    = 1'b1;
    multiplicand = m;
    multiplier   = q;
    @(posedge clock);
    #1;
    ctrl_mult    = 1'b0;
    if (sb.size() > 0) void'(sb.pop_back());  // in-flight op aborted by this start
    sb.push_back(model(m, q, cyc));
    chk("busy_after_start", 64'(busy), 64'd1);
    multiplicand = $urandom;
    multiplier   = $urandom;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(posedge clock);
    #2;
    if (sb.size() != 0) begin
      chk("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  // Monitor: every result_rdy pulse must match the oldest outstanding op.
  always @(negedge clock) begin
    if (reset_n && result_rdy) begin
      if (sb.size() == 0) begin
        chk("spurious_rdy", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("product_hi", product[64:1], e.p);
        chk("product_q1", 64'(product[0]), 64'(e.q1));
        chk("result", 64'(result), 64'(e.p[31:0]));
        chk("mcand_q", 64'(multiplicand_q), 64'(e.m));
        chk("mplier_q", 64'(multiplier_q), 64'(e.q));
        chk("latency", 64'(cyc - e.t0), 64'(e.lat));
        chk("busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  initial begin
    reset_n      = 1'b0;
    ctrl_mult    = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rdy", 64'(result_rdy), 64'd0);
    chk("rst_product", product[63:0], 64'd0);
    chk("rst_operands", {multiplicand_q, multiplier_q}, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // 3 x -7 with inputs scrambled during RUN.
    start_op(32'd3, 32'hFFFF_FFF9);
    wait_drain(40);

    // Most negative squared: exact, and upper half visibly not a sign extension.
    start_op(32'h8000_0000, 32'h8000_0000);
    wait_drain(40);
    chk("ovf_visible", 64'((product[64:32] != '0) && (product[64:32] != '1)), 64'd1);
    repeat (5) @(posedge clock);
    #1;
    chk("hold_product", product[64:1], 64'h4000_0000_0000_0000);
    chk("hold_mcand", 64'(multiplicand_q), 64'h8000_0000);

    // Largest positive times two.
    start_op(32'h7FFF_FFFF, 32'd2);
    wait_drain(40);
    chk("max_x2_hi", 64'(product[64:33]), 64'd0);

    // Reset mid-operation at E10: everything clears at once and no pulse follows.
    start_op(32'd5, 32'd5);
    repeat (10) @(posedge clock);
    #2;
    reset_n = 1'b0;
    void'(sb.pop_back());
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_rdy", 64'(result_rdy), 64'd0);
    chk("arst_product", product[63:0], 64'd0);
    chk("arst_operands", {multiplicand_q, multiplier_q}, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    start_op(32'd6, 32'd7);
    wait_drain(40);

    // Restart at E15 aborts 5x5; only 9x9 completes, 32 cycles after the restart.
    start_op(32'd5, 32'd5);
    repeat (14) @(posedge clock);
    start_op(32'd9, 32'd9);
    wait_drain(40);

    // Start during the DONE cycle: both ops report.
    start_op(32'd11, 32'hFFFF_FFF3);
    repeat (32) @(posedge clock);
    start_op(32'hFFFF_FFFC, 32'd25);
    wait_drain(40);

    // Zero operand.
    start_op(32'd0, 32'd12345);
    wait_drain(40);
    chk("zero_product", product[63:0], 64'd0);

    // Randomised operands, biased towards corner values.
    for (int n = 0; n < 24; n++) begin
      logic [31:0] ops[2];
      for (int k = 0; k < 2; k++) begin
        case ($urandom_range(0, 7))
          0:       ops[k] = 32'h8000_0000;
          1:       ops[k] = 32'h7FFF_FFFF;
          2:       ops[k] = 32'd0;
          3:       ops[k] = 32'hFFFF_FFFF;
          default: ops[k] = $urandom;
        endcase
      end
      start_op(ops[0], ops[1]);
      wait_drain(40);
    end

    repeat (4) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/booth_mult_seq.md
# booth_mult_seq

Sequential radix-2 Booth multiplier for the execute-stage multiply/divide unit. It accepts two signed 32-bit operands on a start pulse and iterates one Booth step per clock. It presents the 65-bit Booth product register and the latched operands to the downstream multiply-overflow checker and result mux. That checker consumes product[64:32] plus the operand sign bits, so all three are held stable after completion.

## Interface
- DATA_W, 32, operand width; product register is 2*DATA_W+1 bits
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- ctrl_mult  in  1  start pulse; sampled every edge
- multiplicand  in  DATA_W  signed operand M, sampled only when ctrl_mult=1
- multiplier  in  DATA_W  signed operand Q, sampled only when ctrl_mult=1
- busy  out  1  high while iterating
- result_rdy  out  1  one-cycle completion pulse
- product  out  2*DATA_W+1  Booth register; [64:1] = signed 64-bit product, [0] = Booth Q-1 bit
- result  out  DATA_W  product[32:1], low word for writeback
- multiplicand_q, multiplier_q  out  DATA_W each  operands latched at start, for the overflow checker

## Operation
- States: IDLE, RUN, DONE.
- Transitions:
  - IDLE→RUN on ctrl_mult.
  - RUN→DONE when iter count = DATA_W-1 is consumed.
  - DONE→IDLE unconditionally after one cycle.
  - ctrl_mult in any state → RUN with fresh operands; a restart aborts the current op with no result_rdy.
- Load: M latched; internal register = {guard=0, A=0, Q=multiplier, Q-1=0}. Count = 0.
- Step, selected by {Q[0], Q-1}:
  - 01: A += M
  - 10: A −= M
  - 00/11: no add
  - Then arithmetic shift right by 1 of {guard, A, Q, Q-1}.
- A is carried as a 33-bit sign-extended accumulator (guard bit) so that A−M never wraps. The product is exact for all operand pairs, including −2^31×−2^31.
- product output = internal register without the guard bit.
- product, result, multiplicand_q and multiplier_q hold their last values until the next start. They are not cleared at DONE.
- Reset (async, any time): state IDLE, count 0, all outputs 0, busy 0, result_rdy 0. An in-flight op is discarded.

## Timing
- Start at edge E0 (ctrl_mult=1): operands latched, busy=1 from E0.
- Iterations occur at edges E1..E32.
- At E32: state DONE, busy=0, result_rdy=1 for the cycle E32–E33.
- Latency: 32 cycles from start edge to result_rdy.
- product is valid while result_rdy=1 and stays valid afterwards.
- Intermediate product values are visible during RUN. Consumers must qualify them with result_rdy.
- ctrl_mult during DONE is accepted and counts as a fresh start. result_rdy still pulses for the completed op in that cycle.

## Configuration
- MULT_ZERO_BYPASS_EN defined: if either operand is 0 at start, skip RUN and go IDLE→DONE directly. product=0, result_rdy at E1 (latency 1).
- Not defined: zero operands take the full 32 iterations. The output values are identical either way.

## Structure
- Package mult_pkg holds:
  - DATA_W, PROD_W = 2*DATA_W+1, ITER_W = $clog2(DATA_W)
  - state enum {IDLE, RUN, DONE}
  - Booth op encoding {NOP, ADD, SUB}
- One sub-module, booth_step: combinational. It takes {guard, A, Q, Q-1} and M and returns the next shifted register. The FSM and counter stay in booth_mult_seq.

## Test plan
- 3 × −7, start pulse, then operand inputs changed during RUN → at E32 result_rdy=1; product[64:1]=−21 (0x…FFEB); multiplicand_q=3; multiplier_q=−7.
- 0x80000000 × 0x80000000 → product[64:1]=0x4000_0000_0000_0000; result=0; product[64:32] not all-equal (overflow visible downstream).
- 0x7FFFFFFF × 2 → result=0xFFFFFFFE; product[64:33]=0.
- Start 5×5, assert reset_n=0 at E10 → all outputs 0 immediately, no result_rdy. Then 6×7 → result 42 at E32.
- Start 5×5, restart with 9×9 at E15 → single result_rdy, 32 cycles after the restart edge; result=81.
- 0 × 12345: with MULT_ZERO_BYPASS_EN, result_rdy at E1 and product=0. Without it, result_rdy at E32 and product=0.
